// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared types for the MEM/WB skid stage: occupancy states and the writeback payload layout.
package mem_wb_skid_stage_pkg;

  localparam int unsigned DefDataLen        = 64;
  localparam int unsigned DefControlLine    = 2;
  localparam int unsigned DefInstructionPart = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Default-width layout; the top re-declares the same field order at its parameter widths.
  typedef struct packed {
    logic [DefControlLine-1:0]     control;
    logic [DefDataLen-1:0]         rd_data;
    logic [DefDataLen-1:0]         addr;
    logic [DefInstructionPart-1:0] instruction_part;
  } wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// Valid/ready handshake and payload bundle between the MEM stage, the skid stage and WB.
interface mem_wb_skid_stage_if #(
  parameter int unsigned DATA_LEN         = 64,
  parameter int unsigned CONTROL_LINE     = 2,
  parameter int unsigned INSTRUCTION_PART = 5
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_LEN-1:0]         rd_data;
  logic [CONTROL_LINE-1:0]     control_in;
  logic [DATA_LEN-1:0]         addr;
  logic [INSTRUCTION_PART-1:0] instruction_part;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_LEN-1:0]         rd_data_out;
  logic [CONTROL_LINE-1:0]     control_out;
  logic [DATA_LEN-1:0]         addr_out;
  logic [INSTRUCTION_PART-1:0] instruction_part_out;

  modport master (
    output in_valid, rd_data, control_in, addr, instruction_part, flush, out_ready,
    input  in_ready, out_valid, rd_data_out, control_out, addr_out, instruction_part_out
  );

  modport slave (
    input  in_valid, rd_data, control_in, addr, instruction_part, flush, out_ready,
    output in_ready, out_valid, rd_data_out, control_out, addr_out, instruction_part_out
  );

endinterface

// File: rtl/wb_payload_reg.sv
// Payload holding register with async reset, synchronous clear (wins over load) and load enable.
module wb_payload_reg
  import mem_wb_skid_stage_pkg::*;
#(
  parameter type payload_t = wb_payload_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  payload_t d,
  output payload_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// Two-entry MEM/WB skid buffer: in_ready depends only on registered state, so out_ready never
// reaches upstream combinationally. Also counts back-pressured cycles.
module mem_wb_skid_stage
  import mem_wb_skid_stage_pkg::*;
#(
  parameter int unsigned DATA_LEN         = 64,
  parameter int unsigned CONTROL_LINE     = 2,
  parameter int unsigned INSTRUCTION_PART = 5,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_wb_skid_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CONTROL_LINE-1:0]     control;
    logic [DATA_LEN-1:0]         rd_data;
    logic [DATA_LEN-1:0]         addr;
    logic [INSTRUCTION_PART-1:0] instruction_part;
  } payload_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  payload_t         in_pl, main_d, main_q, skid_q;
  logic             in_ready, out_valid, accept, consume;
  logic             main_load, skid_load, main_from_skid;
  logic [CNT_W-1:0] stall_cnt_q;

  assign in_pl = '{control:          bus.control_in,
                   rd_data:          bus.rd_data,
                   addr:             bus.addr,
                   instruction_part: bus.instruction_part};

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready;
  assign consume   = out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Register clears are driven by flush directly, so only the state needs overriding here.
    if (bus.flush) begin
      state_d = EMPTY;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  wb_payload_reg #(
    .payload_t (payload_t)
  ) u_main_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (bus.flush),
    .d     (main_d),
    .q     (main_q)
  );

  wb_payload_reg #(
    .payload_t (payload_t)
  ) u_skid_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (bus.flush),
    .d     (in_pl),
    .q     (skid_q)
  );

  // Saturating stall counter; deliberately blind to flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt                = stall_cnt_q;
  assign bus.in_ready             = in_ready;
  assign bus.out_valid            = out_valid;
  assign bus.rd_data_out          = main_q.rd_data;
  assign bus.addr_out             = main_q.addr;
  assign bus.instruction_part_out = main_q.instruction_part;
  // Main keeps stale data after the last consume; mask control so WB sees no write.
  assign bus.control_out          = out_valid ? main_q.control : '0;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed and random bench for mem_wb_skid_stage with a queue scoreboard and occupancy model.
module tb_mem_wb_skid_stage;

  localparam int unsigned DL = 64;
  localparam int unsigned CL = 2;
  localparam int unsigned IP = 5;
  localparam int unsigned CW = 4;
  localparam int          SatMax = 15;

  typedef struct packed {
    logic [CL-1:0] control;
    logic [DL-1:0] rd_data;
    logic [DL-1:0] addr;
    logic [IP-1:0] ip;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] stall_cnt;

  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   stall_exp = 0;
  bit   acc_flag;

  always #5 clk = ~clk;

  mem_wb_skid_stage_if #(.DATA_LEN(DL), .CONTROL_LINE(CL), .INSTRUCTION_PART(IP)) bus ();

  mem_wb_skid_stage #(
    .DATA_LEN         (DL),
    .CONTROL_LINE     (CL),
    .INSTRUCTION_PART (IP),
    .CNT_W            (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [DL-1:0] a);
    bus.addr             = a;
    bus.rd_data          = (a * 3) + 64'h1234_0000_0000_0007;
    bus.control_in       = a[5:4] | 2'b01;
    bus.instruction_part = a[4:0] ^ 5'h15;
  endtask

  // Check the DUT against the model, advance the model, then step to 1 time unit past the edge.
  task automatic cycle();
    bit   mv, mr, consume, accept;
    ent_t head, cur;
    mv = (sb.size() > 0);
    mr = (sb.size() < 2);
    chk("out_valid", bus.out_valid, mv);
    chk("in_ready", bus.in_ready, mr);
    chk("stall_cnt", stall_cnt, stall_exp);
    if (mv) begin
      head = sb[0];
      chk("addr_out", bus.addr_out, head.addr);
      chk("rd_data_out", bus.rd_data_out, head.rd_data);
      chk("control_out", bus.control_out, head.control);
      chk("instr_part_out", bus.instruction_part_out, head.ip);
    end else begin
      chk("control_idle", bus.control_out, 0);
    end
    consume = mv && bus.out_ready;
    accept  = bus.in_valid && mr;
    cur = '{control: bus.control_in, rd_data: bus.rd_data, addr: bus.addr,
            ip: bus.instruction_part};
    if (mv && !bus.out_ready && stall_exp < SatMax) stall_exp++;
    if (consume) void'(sb.pop_front());
    if (bus.flush) sb.delete();
    else if (accept) sb.push_back(cur);
    acc_flag = accept && !bus.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DL-1:0] a);
    bit accepted;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    drive(a);
    for (int i = 0; i < 20 && !accepted; i++) begin
      cycle();
      accepted = acc_flag;
    end
    chk("accept_timeout", accepted, 1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    drive('0);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_addr_out", bus.addr_out, 0);
    chk("rst_control_out", bus.control_out, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: three back-to-back entries, no stalls.
    bus.out_ready = 1'b1;
    send(64'h10);
    send(64'h20);
    send(64'h30);
    repeat (3) cycle();
    chk("stream_stall", stall_cnt, 0);

    // Back-pressure: fill both slots, hold 0xC off, then drain in order.
    bus.out_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    bus.in_valid = 1'b1;
    drive(64'hC);
    repeat (2) cycle();
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_stall", stall_cnt, 3);
    bus.out_ready = 1'b1;
    send(64'hC);
    repeat (3) cycle();
    chk("bp_stall_final", stall_cnt, 3);

    // Flush at TWO with a same-cycle input that must be dropped.
    bus.out_ready = 1'b0;
    send(64'h50);
    send(64'h60);
    bus.in_valid = 1'b1;
    drive(64'h70);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_control", bus.control_out, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // Async reset pulse between edges while holding one entry.
    bus.out_ready = 1'b0;
    send(64'h80);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_addr_out", bus.addr_out, 0);
    chk("arst_rd_data_out", bus.rd_data_out, 0);
    chk("arst_control_out", bus.control_out, 0);
    chk("arst_instr_out", bus.instruction_part_out, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    sb.delete();
    stall_exp = 0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(64'h40);
    repeat (2) cycle();

    // Saturation of the 4-bit stall counter.
    bus.out_ready = 1'b0;
    send(64'h90);
    repeat (20) cycle();
    chk("sat_stall", stall_cnt, SatMax);
    cycle();
    chk("sat_hold", stall_cnt, SatMax);
    bus.out_ready = 1'b1;
    repeat (2) cycle();

    // Random handshake traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid         = 1'($urandom_range(0, 1));
      bus.out_ready        = 1'($urandom_range(0, 1));
      bus.addr             = 64'h1000 + 64'(i);
      bus.rd_data          = {$urandom, $urandom};
      bus.control_in       = CL'($urandom_range(0, 3));
      bus.instruction_part = IP'($urandom_range(0, 31));
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
